// File: rtl/snes_pad_reader.sv
// SNES controller poller: drives latch/clock, shifts in 16 bits, and presents active-high keys.
// Optional SNES_PAD_DEBOUNCE_EN: keys update only when two consecutive valid frames agree.
module snes_pad_reader #(
  parameter int unsigned POLL_PERIOD = 279620,
  parameter int unsigned HALF_PERIOD = 100
) (
  input  logic mclk,
  input  logic gb_bus_rst,
  output logic pad_latch,
  output logic pad_clk,
  input  logic pad_data,
  output logic KeyA,
  output logic KeyB,
  output logic KeySelect,
  output logic KeyStart,
  output logic KeyRight,
  output logic KeyLeft,
  output logic KeyUp,
  output logic KeyDown,
  output logic KeyR,
  output logic KeyL,
  output logic KeyX,
  output logic KeyY,
  output logic pad_present,
  output logic frame_valid
);

  localparam int unsigned PollW = $clog2(POLL_PERIOD + 1);
  localparam int unsigned TmrW  = $clog2(2 * HALF_PERIOD + 1);
  localparam logic [PollW-1:0] PollLast  = PollW'(POLL_PERIOD - 1);
  localparam logic [TmrW-1:0]  LatchLast = TmrW'(2 * HALF_PERIOD - 1);
  localparam logic [TmrW-1:0]  HalfLast  = TmrW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StBitLo, StBitHi, StDone} state_e;

  state_e           state_q, state_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic             pending_q, pending_d;
  logic             start_q;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [3:0]       idx_q, idx_d;
  logic [15:0]      shift_q, shift_d;
  logic [1:0]       sync_q;
  logic [11:0]      keys_q, keys_d;
  logic             present_q, present_d;
  logic             latch_q, pclk_q;
  logic             wrap, take, frame_ok;
  logic [11:0]      pressed;

`ifdef SNES_PAD_DEBOUNCE_EN
  logic [11:0] hist_q, hist_d;
  logic        hist_vld_q, hist_vld_d;
`endif

  assign wrap      = (poll_q == PollLast);
  assign poll_d    = wrap ? '0 : poll_q + 1'b1;
  // A wrap always wins so a poll is never lost, only deferred to the next IDLE.
  assign pending_d = wrap | (pending_q & ~take);
  assign frame_ok  = &shift_q[15:12];
  assign pressed   = ~shift_q[11:0];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q || start_q) begin
          take    = 1'b1;
          tmr_d   = '0;
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (tmr_q == LatchLast) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = StBitLo;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StBitLo: begin
        if (tmr_q == HalfLast) begin
          tmr_d          = '0;
          shift_d[idx_q] = sync_q[1];
          state_d        = StBitHi;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StBitHi: begin
        if (tmr_q == HalfLast) begin
          tmr_d = '0;
          if (idx_q == 4'd15) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StBitLo;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    keys_d    = keys_q;
    present_d = present_q;
`ifdef SNES_PAD_DEBOUNCE_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
`endif
    if (state_q == StDone) begin
      if (frame_ok) begin
        present_d = 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
        if (hist_vld_q && (hist_q == pressed)) keys_d = pressed;
        hist_d     = pressed;
        hist_vld_d = 1'b1;
`else
        keys_d = pressed;
`endif
      end else begin
        present_d = 1'b0;
        keys_d    = '0;
`ifdef SNES_PAD_DEBOUNCE_EN
        hist_vld_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge mclk or posedge gb_bus_rst) begin
    if (gb_bus_rst) begin
      state_q   <= StIdle;
      poll_q    <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b1;
      tmr_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      sync_q    <= 2'b11;
      keys_q    <= '0;
      present_q <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      poll_q    <= poll_d;
      pending_q <= pending_d;
      start_q   <= 1'b0;
      tmr_q     <= tmr_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      sync_q    <= {sync_q[0], pad_data};
      keys_q    <= keys_d;
      present_q <= present_d;
      // Pad pins come straight from flops so they never glitch.
      latch_q   <= (state_d == StLatch);
      pclk_q    <= (state_d != StBitLo);
    end
  end

`ifdef SNES_PAD_DEBOUNCE_EN
  always_ff @(posedge mclk or posedge gb_bus_rst) begin
    if (gb_bus_rst) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end
`endif

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign frame_valid = (state_q == StDone);
  assign pad_present = present_q;
  assign KeyB        = keys_q[0];
  assign KeyY        = keys_q[1];
  assign KeySelect   = keys_q[2];
  assign KeyStart    = keys_q[3];
  assign KeyUp       = keys_q[4];
  assign KeyDown     = keys_q[5];
  assign KeyLeft     = keys_q[6];
  assign KeyRight    = keys_q[7];
  assign KeyA        = keys_q[8];
  assign KeyX        = keys_q[9];
  assign KeyL        = keys_q[10];
  assign KeyR        = keys_q[11];

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader: a pad model serves frames, a monitor checks every DONE.
module tb_snes_pad_reader;

  localparam int unsigned HP       = 4;
  localparam int unsigned PP       = 200;
  localparam int unsigned PP2      = 100;
  localparam int unsigned FrameCyc = 34 * HP;

  logic        mclk = 1'b0;
  logic        rst  = 1'b0;
  logic        pad_latch, pad_clk, pad_data;
  logic [11:0] keys;
  logic        pad_present, frame_valid;
  logic        latch2, pclk2, present2, fv2;
  logic [11:0] keys2;

  int tests = 0;
  int fails = 0;

  always #5 mclk = ~mclk;

  snes_pad_reader #(.POLL_PERIOD(PP), .HALF_PERIOD(HP)) dut (
    .mclk(mclk), .gb_bus_rst(rst), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pad_data), .KeyA(keys[8]), .KeyB(keys[0]), .KeySelect(keys[2]),
    .KeyStart(keys[3]), .KeyRight(keys[7]), .KeyLeft(keys[6]), .KeyUp(keys[4]),
    .KeyDown(keys[5]), .KeyR(keys[11]), .KeyL(keys[10]), .KeyX(keys[9]), .KeyY(keys[1]),
    .pad_present(pad_present), .frame_valid(frame_valid)
  );

  // Misconfigured poll rate (shorter than a frame): frames must run back-to-back.
  snes_pad_reader #(.POLL_PERIOD(PP2), .HALF_PERIOD(HP)) dut2 (
    .mclk(mclk), .gb_bus_rst(rst), .pad_latch(latch2), .pad_clk(pclk2),
    .pad_data(1'b1), .KeyA(keys2[8]), .KeyB(keys2[0]), .KeySelect(keys2[2]),
    .KeyStart(keys2[3]), .KeyRight(keys2[7]), .KeyLeft(keys2[6]), .KeyUp(keys2[4]),
    .KeyDown(keys2[5]), .KeyR(keys2[11]), .KeyL(keys2[10]), .KeyX(keys2[9]), .KeyY(keys2[1]),
    .pad_present(present2), .frame_valid(fv2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // ---------------- pad model + reference model ----------------
  logic [15:0] directed [8] = '{16'hFFFF, 16'hFEFE, 16'h0FFF, 16'hFFFF,
                                16'hFEFF, 16'hFFFF, 16'hFEFF, 16'hFEFF};
  logic [15:0] cur_raw   = 16'hFFFF;
  logic [15:0] last_raw  = 16'hFFFF;
  logic [15:0] force_raw = 16'hFEFE;
  logic        use_force = 1'b0;
  int unsigned bit_k     = 16;
  int unsigned fr_idx    = 0;
  logic [15:0] r_sel;
  int unsigned sel;
  logic [31:0] rnd;
  logic [12:0] exp_q [$];
  logic [11:0] m_keys = '0;
`ifdef SNES_PAD_DEBOUNCE_EN
  logic [11:0] m_hist = '0;
  logic        m_hist_vld = 1'b0;
`endif

  task automatic model_push(input logic [15:0] r);
    logic [11:0] p;
    p = ~r[11:0];
    if (r[15:12] != 4'hF) begin
      m_keys = '0;
`ifdef SNES_PAD_DEBOUNCE_EN
      m_hist_vld = 1'b0;
`endif
      exp_q.push_back({1'b0, 12'h000});
    end else begin
`ifdef SNES_PAD_DEBOUNCE_EN
      if (m_hist_vld && (m_hist == p)) m_keys = p;
      m_hist     = p;
      m_hist_vld = 1'b1;
`else
      m_keys = p;
`endif
      exp_q.push_back({1'b1, m_keys});
    end
  endtask

  always @(posedge pad_latch) begin
    if (use_force) r_sel = force_raw;
    else if (fr_idx < 8) r_sel = directed[fr_idx];
    else begin
      sel = $urandom_range(0, 7);
      rnd = $urandom;
      if (sel == 0) r_sel = rnd[15:0];
      else if (sel < 3) r_sel = last_raw;
      else r_sel = {4'hF, rnd[11:0]};
    end
    cur_raw  = r_sel;
    last_raw = r_sel;
    bit_k    = 0;
    fr_idx++;
    model_push(r_sel);
  end

  always @(posedge pad_clk) if (!pad_latch && bit_k < 16) bit_k++;
  assign pad_data = (bit_k < 16) ? cur_raw[bit_k[3:0]] : 1'b1;

  // ---------------- monitor ----------------
  int unsigned cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  logic [12:0] cur_exp = '0;
  logic [12:0] pop_exp = '0;
  logic        chk_next = 1'b0, latch_prev = 1'b0, pclk_prev = 1'b1, prev_rise_ok = 1'b0;
  int unsigned prev_rise = 0, latch_w = 0, lo_w = 0, lo_pulses = 0, fv_cnt = 0;

  always @(negedge mclk) begin
    if (rst) begin
      exp_q.delete();
      m_keys = '0;
`ifdef SNES_PAD_DEBOUNCE_EN
      m_hist_vld = 1'b0;
`endif
      cur_exp = '0; chk_next = 1'b0; prev_rise_ok = 1'b0;
      latch_w = 0; lo_w = 0; lo_pulses = 0; latch_prev = 1'b0; pclk_prev = 1'b1;
    end else begin
      if (chk_next) begin
        check("frame_keys", {pad_present, keys}, pop_exp);
        cur_exp  = pop_exp;
        chk_next = 1'b0;
      end else begin
        check("keys_stable", {pad_present, keys}, cur_exp);
      end
      if (pad_latch && !latch_prev) begin
        if (prev_rise_ok) check("poll_period", cyc - prev_rise, PP);
        prev_rise = cyc; prev_rise_ok = 1'b1; lo_pulses = 0;
      end
      if (pad_latch) latch_w++;
      else if (latch_prev) begin
        check("latch_width", latch_w, 2 * HP);
        latch_w = 0;
      end
      if (!pad_clk) lo_w++;
      else if (!pclk_prev) begin
        check("clk_low_width", lo_w, HP);
        lo_w = 0;
        lo_pulses++;
      end
      if (frame_valid) begin
        fv_cnt++;
        check("fv_latency", cyc - prev_rise, FrameCyc);
        check("clk_pulses", lo_pulses, 16);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          pop_exp  = exp_q.pop_front();
          chk_next = 1'b1;
        end
      end
      latch_prev = pad_latch;
      pclk_prev  = pad_clk;
    end
  end

  logic        l2_prev = 1'b0, l2_ok = 1'b0;
  int unsigned l2_rise = 0;
  always @(negedge mclk) begin
    if (rst) begin
      l2_prev = 1'b0; l2_ok = 1'b0;
    end else begin
      if (latch2 && !l2_prev) begin
        if (l2_ok) check("b2b_period", cyc - l2_rise, FrameCyc + 2);
        l2_rise = cyc; l2_ok = 1'b1;
      end
      l2_prev = latch2;
    end
  end

  // ---------------- main sequence ----------------
  task automatic wait_frames(input int unsigned n);
    int unsigned start, budget;
    start  = fv_cnt;
    budget = n * (PP + 50) + 50;
    while (fv_cnt < start + n && budget > 0) begin
      @(negedge mclk);
      budget--;
    end
    if (budget == 0) begin
      tests++; fails++;
      $display("FAIL frame_timeout: got %0d frames, want %0d", fv_cnt - start, n);
    end
  endtask

  initial begin
    int unsigned budget;
    #1 rst = 1'b1;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("reset_latch", pad_latch, 0);
    check("reset_clk", pad_clk, 1);
    check("reset_keys", {pad_present, keys}, 0);
    check("reset_fv", frame_valid, 0);
    rst = 1'b0;
    @(negedge mclk);
    check("first_latch", pad_latch, 1);
    wait_frames(12);

    use_force = 1'b1;
    wait_frames(3);
    budget = 600;
    while (!(lo_pulses == 7 && !pad_clk && !pad_latch) && budget > 0) begin
      @(negedge mclk);
      budget--;
    end
    check("bit7_reached", (budget != 0), 1);
    check("pre_rst_keys", {pad_present, keys}, 13'h1101);
    #2 rst = 1'b1;
    #1;
    check("rst_clk", pad_clk, 1);
    check("rst_latch", pad_latch, 0);
    check("rst_keys", {pad_present, keys}, 0);
    check("rst_fv", frame_valid, 0);
    use_force = 1'b0;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
    check("restart_latch", pad_latch, 1);
    wait_frames(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
